// File: rtl/nios2_subsystem_mul_sequencer.sv
// Sequencer and round-robin arbiter for the shared three-product 16x16
// multiplier cell. One or two passes produce the low word (and optionally
// the high word) of an unsigned 32x32 product. Each result is returned on
// a single response channel that is tagged with the requester id.
//
// Handshakes: a transfer happens on a rising edge where valid & ready are
// both high. Once valid is raised, the payload is held stable until that
// edge. Requester readys are only ever raised in IDLE. The response stays
// valid, with its data frozen, until rsp_ready is seen.
module nios2_subsystem_mul_sequencer #(
    parameter logic HI_SUPPORT = 1'b1
) (
    input  logic        clk,
    input  logic        reset_n,
    input  logic        r0_valid,
    input  logic        r1_valid,
    output logic        r0_ready,
    output logic        r1_ready,
    input  logic [31:0] r0_a,
    input  logic [31:0] r0_b,
    input  logic [31:0] r1_a,
    input  logic [31:0] r1_b,
    input  logic        r0_hi,
    input  logic        r1_hi,
    output logic [31:0] mul_src1,
    output logic [31:0] mul_src2,
    output logic        mul_en,
    input  logic [31:0] mul_p1,
    input  logic [31:0] mul_p2,
    input  logic [31:0] mul_p3,
    output logic        rsp_valid,
    input  logic        rsp_ready,
    output logic        rsp_id,
    output logic [31:0] rsp_lo,
    output logic [31:0] rsp_hi,
    output logic        busy,
    output logic [2:0]  state_dbg
);

    typedef enum logic [2:0] {
        S_IDLE = 3'd0,
        S_LO   = 3'd1,
        S_HI   = 3'd2,
        S_ACC  = 3'd3,
        S_RESP = 3'd4
    } state_t;

    state_t      state_q, state_d;
    logic        last_grant_q, last_grant_d;
    logic [31:0] a_q, a_d;
    logic [31:0] b_q, b_d;
    logic        id_q, id_d;
    logic        want_hi_q, want_hi_d;
    logic [48:0] part_q, part_d;
    logic [31:0] rsp_lo_q, rsp_lo_d;
    logic [31:0] rsp_hi_q, rsp_hi_d;

    logic        grant0, grant1, accept;
    logic [32:0] pp_sum;
    logic [48:0] lo_sum;
    logic [63:0] full_sum;

    // Round-robin grant: a lone requester wins; on contention the one not served last wins.
    always_comb begin
        grant0 = 1'b0;
        grant1 = 1'b0;
        if (state_q == S_IDLE) begin
            grant0 = r0_valid & (~r1_valid | last_grant_q);
            grant1 = r1_valid & (~r0_valid | ~last_grant_q);
        end
        accept = grant0 | grant1;
    end

    // Combine partial products; the p2+p3 carry (bit 32) is kept before the shift.
    always_comb begin
        pp_sum   = {1'b0, mul_p2} + {1'b0, mul_p3};
        lo_sum   = {17'd0, mul_p1} + ({16'd0, pp_sum} << 16);
        full_sum = {15'd0, part_q} + {mul_p1, 32'd0};
    end

    // State register.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q <= S_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // Next-state logic.
    always_comb begin
        state_d = state_q;
        case (state_q)
            S_IDLE:  if (accept) state_d = S_LO;
            S_LO:    state_d = want_hi_q ? S_HI : S_ACC;
            S_HI:    state_d = S_ACC;
            S_ACC:   state_d = S_RESP;
            S_RESP:  if (rsp_ready) state_d = S_IDLE;
            default: state_d = S_IDLE;
        endcase
    end

    // Outputs decoded from state; readys are also held low while reset is asserted.
    always_comb begin
        r0_ready  = grant0 & reset_n;
        r1_ready  = grant1 & reset_n;
        mul_en    = 1'b0;
        mul_src1  = 32'd0;
        mul_src2  = 32'd0;
        rsp_valid = (state_q == S_RESP);
        busy      = (state_q != S_IDLE);
        state_dbg = state_q;
        case (state_q)
            S_LO: begin
                mul_en   = 1'b1;
                mul_src1 = a_q;
                mul_src2 = b_q;
            end
            S_HI: begin
                mul_en   = 1'b1;
                mul_src1 = {16'h0, a_q[31:16]};
                mul_src2 = {16'h0, b_q[31:16]};
            end
            default: ;
        endcase
        rsp_id = id_q;
        rsp_lo = rsp_lo_q;
        rsp_hi = rsp_hi_q;
    end

    // Datapath next values: capture on accept, partial sum in HI, result in ACC.
    always_comb begin
        last_grant_d = last_grant_q;
        a_d          = a_q;
        b_d          = b_q;
        id_d         = id_q;
        want_hi_d    = want_hi_q;
        part_d       = part_q;
        rsp_lo_d     = rsp_lo_q;
        rsp_hi_d     = rsp_hi_q;
        if (accept) begin
            a_d          = grant1 ? r1_a : r0_a;
            b_d          = grant1 ? r1_b : r0_b;
            id_d         = grant1;
            want_hi_d    = (grant1 ? r1_hi : r0_hi) & HI_SUPPORT;
            last_grant_d = grant1;
        end
        if (state_q == S_HI) begin
            part_d = lo_sum;
        end
        if (state_q == S_ACC) begin
            if (want_hi_q) begin
                rsp_lo_d = full_sum[31:0];
                rsp_hi_d = full_sum[63:32];
            end else begin
                rsp_lo_d = lo_sum[31:0];
                rsp_hi_d = 32'd0;
            end
        end
    end

    // Datapath registers; last_grant starts at 1 so requester 0 wins the first contention.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            last_grant_q <= 1'b1;
            a_q          <= 32'd0;
            b_q          <= 32'd0;
            id_q         <= 1'b0;
            want_hi_q    <= 1'b0;
            part_q       <= 49'd0;
            rsp_lo_q     <= 32'd0;
            rsp_hi_q     <= 32'd0;
        end else begin
            last_grant_q <= last_grant_d;
            a_q          <= a_d;
            b_q          <= b_d;
            id_q         <= id_d;
            want_hi_q    <= want_hi_d;
            part_q       <= part_d;
            rsp_lo_q     <= rsp_lo_d;
            rsp_hi_q     <= rsp_hi_d;
        end
    end

endmodule

// File: tb/tb_nios2_subsystem_mul_sequencer.sv
// Bench for nios2_subsystem_mul_sequencer. Two instances share the request
// and response-ready inputs: one built with the high pass and one without.
// Each instance has its own behavioural model of the 16x16 cell.
module tb_nios2_subsystem_mul_sequencer;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        reset_n = 1'b0;
  logic        r0_valid = 1'b0, r1_valid = 1'b0;
  logic [31:0] r0_a = '0, r0_b = '0, r1_a = '0, r1_b = '0;
  logic        r0_hi = 1'b0, r1_hi = 1'b0;
  logic        rsp_ready = 1'b0;

  logic        r0_ready, r1_ready, mul_en, rsp_valid, rsp_id, busy;
  logic [31:0] mul_src1, mul_src2, rsp_lo, rsp_hi;
  logic [31:0] mul_p1 = '0, mul_p2 = '0, mul_p3 = '0;
  logic [2:0]  state_dbg;

  logic        n_r0_ready, n_r1_ready, n_mul_en, n_rsp_valid, n_rsp_id, n_busy;
  logic [31:0] n_mul_src1, n_mul_src2, n_rsp_lo, n_rsp_hi;
  logic [31:0] n_mul_p1 = '0, n_mul_p2 = '0, n_mul_p3 = '0;
  logic [2:0]  n_state_dbg;

  int   n_cmp = 0;
  int   n_bad = 0;
  logic m_last;  // model of which requester was served last

  nios2_subsystem_mul_sequencer #(.HI_SUPPORT(1'b1)) dut (
    .clk(clk), .reset_n(reset_n),
    .r0_valid(r0_valid), .r1_valid(r1_valid), .r0_ready(r0_ready), .r1_ready(r1_ready),
    .r0_a(r0_a), .r0_b(r0_b), .r1_a(r1_a), .r1_b(r1_b), .r0_hi(r0_hi), .r1_hi(r1_hi),
    .mul_src1(mul_src1), .mul_src2(mul_src2), .mul_en(mul_en),
    .mul_p1(mul_p1), .mul_p2(mul_p2), .mul_p3(mul_p3),
    .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_id(rsp_id),
    .rsp_lo(rsp_lo), .rsp_hi(rsp_hi), .busy(busy), .state_dbg(state_dbg)
  );

  nios2_subsystem_mul_sequencer #(.HI_SUPPORT(1'b0)) dut_nohi (
    .clk(clk), .reset_n(reset_n),
    .r0_valid(r0_valid), .r1_valid(r1_valid), .r0_ready(n_r0_ready), .r1_ready(n_r1_ready),
    .r0_a(r0_a), .r0_b(r0_b), .r1_a(r1_a), .r1_b(r1_b), .r0_hi(r0_hi), .r1_hi(r1_hi),
    .mul_src1(n_mul_src1), .mul_src2(n_mul_src2), .mul_en(n_mul_en),
    .mul_p1(n_mul_p1), .mul_p2(n_mul_p2), .mul_p3(n_mul_p3),
    .rsp_valid(n_rsp_valid), .rsp_ready(rsp_ready), .rsp_id(n_rsp_id),
    .rsp_lo(n_rsp_lo), .rsp_hi(n_rsp_hi), .busy(n_busy), .state_dbg(n_state_dbg)
  );

  // Behavioural multiplier cells: three 16x16 products registered under enable.
  always @(posedge clk) begin
    if (mul_en) begin
      mul_p1 <= {16'h0, mul_src1[15:0]} * {16'h0, mul_src2[15:0]};
      mul_p2 <= {16'h0, mul_src1[15:0]} * {16'h0, mul_src2[31:16]};
      mul_p3 <= {16'h0, mul_src1[31:16]} * {16'h0, mul_src2[15:0]};
    end
    if (n_mul_en) begin
      n_mul_p1 <= {16'h0, n_mul_src1[15:0]} * {16'h0, n_mul_src2[15:0]};
      n_mul_p2 <= {16'h0, n_mul_src1[15:0]} * {16'h0, n_mul_src2[31:16]};
      n_mul_p3 <= {16'h0, n_mul_src1[31:16]} * {16'h0, n_mul_src2[15:0]};
    end
  end

  function automatic logic [63:0] ref_mul(input logic [31:0] a, input logic [31:0] b);
    return {32'd0, a} * {32'd0, b};
  endfunction

  // Drives one request from a single requester and observes both instances
  // until the full-featured one raises rsp_valid (cycles counted from the accept edge).
  task automatic do_request(input logic id, input logic [31:0] a, input logic [31:0] b,
                            input logic hi, input logic rr_early, input logic complete,
                            output logic rdy, output int lat, output logic [31:0] lo_o,
                            output logic [31:0] hi_o, output logic id_o, output logic [7:0] en_mask,
                            output int n_lat, output logic [31:0] n_lo_o, output logic [31:0] n_hi_o);
    @(posedge clk); #1;
    if (id) begin r1_valid = 1'b1; r1_a = a; r1_b = b; r1_hi = hi; end
    else    begin r0_valid = 1'b1; r0_a = a; r0_b = b; r0_hi = hi; end
    rsp_ready = rr_early;
    #1;
    rdy = id ? r1_ready : r0_ready;
    @(posedge clk); #1;
    r0_valid = 1'b0; r1_valid = 1'b0;
    m_last = id;
    lat = -1; n_lat = -1; en_mask = '0;
    lo_o = '0; hi_o = '0; id_o = 1'b0; n_lo_o = '0; n_hi_o = '0;
    for (int c = 1; c <= 20 && lat < 0; c++) begin
      @(negedge clk);
      if (c < 8) en_mask[c] = mul_en;
      if (n_rsp_valid && n_lat < 0) begin n_lat = c; n_lo_o = n_rsp_lo; n_hi_o = n_rsp_hi; end
      if (rsp_valid) begin lat = c; lo_o = rsp_lo; hi_o = rsp_hi; id_o = rsp_id; end
    end
    if (complete) begin
      rsp_ready = 1'b1;
      @(posedge clk); #1;
      rsp_ready = 1'b0;
    end
  endtask

  task automatic test_reset();
    reset_n = 1'b0; r0_valid = 1'b1; r1_valid = 1'b1; rsp_ready = 1'b0;
    repeat (2) @(negedge clk);
    n_cmp++;
    if ({r0_ready, r1_ready, rsp_valid, busy, mul_en, rsp_id, state_dbg} !== 9'd0) begin
      n_bad++;
      $display("FAIL reset_ctrl: got %b expected 0",
               {r0_ready, r1_ready, rsp_valid, busy, mul_en, rsp_id, state_dbg});
    end
    n_cmp++;
    if ({mul_src1, mul_src2, rsp_lo, rsp_hi} !== 128'd0) begin
      n_bad++;
      $display("FAIL reset_data: got %h expected 0", {mul_src1, mul_src2, rsp_lo, rsp_hi});
    end
    r0_valid = 1'b0; r1_valid = 1'b0;
    reset_n = 1'b1;
    m_last = 1'b1;
    @(negedge clk);
    n_cmp++;
    if ({busy, rsp_valid, r0_ready, r1_ready, n_busy, n_rsp_valid} !== 6'd0) begin
      n_bad++;
      $display("FAIL reset_release_idle: got %b expected 0",
               {busy, rsp_valid, r0_ready, r1_ready, n_busy, n_rsp_valid});
    end
  endtask

  task automatic test_directed();
    logic rdy, rid; int lat, nlat; logic [31:0] lo, hi, nlo, nhi; logic [7:0] em;
    // 3 * 5, low word only, rsp_ready raised before the response
    do_request(1'b0, 32'd3, 32'd5, 1'b0, 1'b1, 1'b1, rdy, lat, lo, hi, rid, em, nlat, nlo, nhi);
    n_cmp++; if (rdy !== 1'b1) begin n_bad++; $display("FAIL d1_ready: got %b expected 1", rdy); end
    n_cmp++; if (lat !== 3) begin n_bad++; $display("FAIL d1_latency: got %0d expected 3", lat); end
    n_cmp++;
    if ({rid, hi, lo} !== {1'b0, 32'h0, 32'h0000000F}) begin
      n_bad++; $display("FAIL d1_result: got %h expected %h", {rid, hi, lo}, {1'b0, 32'h0, 32'h0000000F});
    end
    n_cmp++; if (em !== 8'b0000_0010) begin n_bad++; $display("FAIL d1_mul_en: got %b expected 00000010", em); end
    // all-ones squared with high word, from requester 1
    do_request(1'b1, 32'hFFFFFFFF, 32'hFFFFFFFF, 1'b1, 1'b0, 1'b1, rdy, lat, lo, hi, rid, em, nlat, nlo, nhi);
    n_cmp++; if (rdy !== 1'b1) begin n_bad++; $display("FAIL d2_ready: got %b expected 1", rdy); end
    n_cmp++; if (lat !== 4) begin n_bad++; $display("FAIL d2_latency: got %0d expected 4", lat); end
    n_cmp++;
    if ({rid, hi, lo} !== {1'b1, 32'hFFFFFFFE, 32'h00000001}) begin
      n_bad++; $display("FAIL d2_result: got %h expected %h", {rid, hi, lo}, {1'b1, 32'hFFFFFFFE, 32'h00000001});
    end
    n_cmp++; if (em !== 8'b0000_0110) begin n_bad++; $display("FAIL d2_mul_en: got %b expected 00000110", em); end
    n_cmp++;
    if ({nlat == 3, nhi, nlo} !== {1'b1, 32'h0, 32'h00000001}) begin
      n_bad++; $display("FAIL d2_nohi: got lat %0d %h_%h expected lat 3 00000000_00000001", nlat, nhi, nlo);
    end
    // 2^16 * 2^16: the product lands exactly in the high word
    do_request(1'b0, 32'h00010000, 32'h00010000, 1'b1, 1'b1, 1'b1, rdy, lat, lo, hi, rid, em, nlat, nlo, nhi);
    n_cmp++;
    if ({hi, lo} !== {32'h1, 32'h0}) begin
      n_bad++; $display("FAIL d3_result: got %h_%h expected 00000001_00000000", hi, lo);
    end
    n_cmp++;
    if ({nlat == 3, nhi, nlo} !== {1'b1, 64'd0}) begin
      n_bad++; $display("FAIL d3_nohi: got lat %0d %h_%h expected lat 3 0_0", nlat, nhi, nlo);
    end
  endtask

  task automatic test_random();
    logic rdy, rid, id, hi_req; int lat, nlat; logic [31:0] lo, hi, nlo, nhi, a, b; logic [7:0] em;
    logic [63:0] p;
    for (int i = 0; i < 24; i++) begin
      id = 1'($urandom_range(0, 1));
      a = $urandom; b = $urandom;
      if ($urandom_range(0, 3) == 0) a = 32'hFFFFFFFF;
      if ($urandom_range(0, 3) == 0) b = {$urandom_range(0, 65535)} << 16;
      hi_req = 1'($urandom_range(0, 1));
      p = ref_mul(a, b);
      do_request(id, a, b, hi_req, 1'($urandom_range(0, 1)), 1'b1, rdy, lat, lo, hi, rid, em, nlat, nlo, nhi);
      n_cmp++; if (rdy !== 1'b1) begin n_bad++; $display("FAIL rnd%0d_ready: got %b expected 1", i, rdy); end
      n_cmp++;
      if (lat !== (hi_req ? 4 : 3)) begin
        n_bad++; $display("FAIL rnd%0d_latency: got %0d expected %0d", i, lat, hi_req ? 4 : 3);
      end
      n_cmp++;
      if ({rid, hi, lo} !== {id, hi_req ? p[63:32] : 32'h0, p[31:0]}) begin
        n_bad++; $display("FAIL rnd%0d_result: a %h b %h got %h expected %h", i, a, b,
                          {rid, hi, lo}, {id, hi_req ? p[63:32] : 32'h0, p[31:0]});
      end
      n_cmp++;
      if ({nlat == 3, nhi, nlo} !== {1'b1, 32'h0, p[31:0]}) begin
        n_bad++; $display("FAIL rnd%0d_nohi: got lat %0d %h_%h expected lat 3 00000000_%h", i, nlat, nhi, nlo, p[31:0]);
      end
    end
  endtask

  task automatic test_stall();
    logic rdy, rid; int lat, nlat; logic [31:0] lo, hi, nlo, nhi, a, b; logic [7:0] em;
    logic [63:0] p; logic [68:0] exp_v, got_v;
    a = $urandom; b = $urandom; p = ref_mul(a, b);
    do_request(1'b1, a, b, 1'b1, 1'b0, 1'b0, rdy, lat, lo, hi, rid, em, nlat, nlo, nhi);
    r0_valid = 1'b1; r1_valid = 1'b1;
    exp_v = {1'b1, 1'b1, 2'b00, 1'b0, 1'b1, p[63:32], p[31:0]};
    for (int c = 0; c < 10; c++) begin
      @(negedge clk);
      got_v = {rsp_valid, busy, r0_ready, r1_ready, mul_en, rsp_id, rsp_hi, rsp_lo};
      n_cmp++;
      if (got_v !== exp_v) begin
        n_bad++; $display("FAIL stall_c%0d: got %h expected %h", c, got_v, exp_v);
      end
    end
    r0_valid = 1'b0; r1_valid = 1'b0;
    rsp_ready = 1'b1;
    @(posedge clk); #1;
    rsp_ready = 1'b0;
    n_cmp++;
    if ({busy, rsp_valid} !== 2'b00) begin
      n_bad++; $display("FAIL stall_release: got %b expected 00", {busy, rsp_valid});
    end
  endtask

  task automatic test_reset_mid();
    logic rdy, rid; int lat, nlat; logic [31:0] lo, hi, nlo, nhi, a, b; logic [7:0] em;
    logic [63:0] p;
    @(posedge clk); #1;
    r0_valid = 1'b1; r0_a = $urandom; r0_b = $urandom; r0_hi = 1'b1;
    @(posedge clk); #1;          // accept edge passed, now in the LO cycle
    r0_valid = 1'b0;
    @(posedge clk); #2;          // now in the HI cycle
    n_cmp++;
    if ({mul_en, busy, rsp_valid} !== 3'b110) begin
      n_bad++; $display("FAIL rmid_in_hi: got %b expected 110", {mul_en, busy, rsp_valid});
    end
    reset_n = 1'b0; r0_valid = 1'b1; r1_valid = 1'b1;
    #1;
    n_cmp++;
    if ({r0_ready, r1_ready, mul_en, rsp_valid, rsp_id, busy, state_dbg, mul_src1, mul_src2, rsp_lo, rsp_hi} !== '0) begin
      n_bad++; $display("FAIL rmid_async_zero: got %h expected 0",
                        {r0_ready, r1_ready, mul_en, rsp_valid, rsp_id, busy, state_dbg, mul_src1, mul_src2, rsp_lo, rsp_hi});
    end
    n_cmp++;
    if ({n_r0_ready, n_r1_ready, n_mul_en, n_rsp_valid, n_busy, n_rsp_lo, n_rsp_hi} !== '0) begin
      n_bad++; $display("FAIL rmid_nohi_zero: got %h expected 0",
                        {n_r0_ready, n_r1_ready, n_mul_en, n_rsp_valid, n_busy, n_rsp_lo, n_rsp_hi});
    end
    repeat (2) @(negedge clk);
    r0_valid = 1'b0; r1_valid = 1'b0;
    reset_n = 1'b1;
    m_last = 1'b1;
    for (int c = 0; c < 8; c++) begin
      @(negedge clk);
      n_cmp++;
      if ({rsp_valid, busy, n_rsp_valid} !== 3'b000) begin
        n_bad++; $display("FAIL rmid_no_rsp_c%0d: got %b expected 000", c, {rsp_valid, busy, n_rsp_valid});
      end
    end
    a = $urandom; b = $urandom; p = ref_mul(a, b);
    do_request(1'b0, a, b, 1'b1, 1'b0, 1'b1, rdy, lat, lo, hi, rid, em, nlat, nlo, nhi);
    n_cmp++;
    if ({lat == 4, rid, hi, lo} !== {1'b1, 1'b0, p}) begin
      n_bad++; $display("FAIL rmid_after: got lat %0d %h expected lat 4 %h", lat, {rid, hi, lo}, {1'b0, p});
    end
  endtask

  task automatic test_back_to_back();
    logic [64:0] exp_q[$];
    logic [64:0] exp_v;
    logic [63:0] p;
    logic        gid, prev_hi, want;
    int          n_acc, n_rsp, prev_acc;
    n_acc = 0; n_rsp = 0; prev_acc = -1; prev_hi = 1'b0;
    @(posedge clk); #1;
    r0_valid = 1'b1; r1_valid = 1'b1; rsp_ready = 1'b1;
    r0_a = $urandom; r0_b = $urandom; r0_hi = 1'($urandom_range(0, 1));
    r1_a = $urandom; r1_b = $urandom; r1_hi = 1'($urandom_range(0, 1));
    for (int cyc = 0; cyc < 300 && n_rsp < 8; cyc++) begin
      @(negedge clk);
      if (r0_ready || r1_ready) begin
        gid = ~m_last;
        n_cmp++;
        if ({r1_ready, r0_ready} !== (gid ? 2'b10 : 2'b01)) begin
          n_bad++; $display("FAIL b2b_grant%0d: got %b expected %b", n_acc, {r1_ready, r0_ready}, gid ? 2'b10 : 2'b01);
        end
        if (prev_acc >= 0) begin
          n_cmp++;
          if (cyc - prev_acc != (prev_hi ? 5 : 4)) begin
            n_bad++; $display("FAIL b2b_interval%0d: got %0d expected %0d", n_acc, cyc - prev_acc, prev_hi ? 5 : 4);
          end
        end
        want = gid ? r1_hi : r0_hi;
        p = gid ? ref_mul(r1_a, r1_b) : ref_mul(r0_a, r0_b);
        exp_q.push_back({gid, want ? p[63:32] : 32'h0, p[31:0]});
        m_last = gid; prev_acc = cyc; prev_hi = want;
        n_acc++;
      end
      if (rsp_valid) begin
        n_cmp++;
        if (exp_q.size() == 0) begin
          n_bad++; $display("FAIL b2b_unexpected_rsp: got %h expected none", {rsp_id, rsp_hi, rsp_lo});
        end else begin
          exp_v = exp_q.pop_front();
          if ({rsp_id, rsp_hi, rsp_lo} !== exp_v) begin
            n_bad++; $display("FAIL b2b_rsp%0d: got %h expected %h", n_rsp, {rsp_id, rsp_hi, rsp_lo}, exp_v);
          end
        end
        n_rsp++;
      end
      @(posedge clk); #1;
      r0_a = $urandom; r0_b = $urandom; r0_hi = 1'($urandom_range(0, 1));
      r1_a = $urandom; r1_b = $urandom; r1_hi = 1'($urandom_range(0, 1));
      if (n_acc >= 8) begin r0_valid = 1'b0; r1_valid = 1'b0; end
    end
    n_cmp++;
    if (n_rsp != 8 || n_acc != 8) begin
      n_bad++; $display("FAIL b2b_count: got %0d accepts %0d responses expected 8 and 8", n_acc, n_rsp);
    end
    r0_valid = 1'b0; r1_valid = 1'b0;
    repeat (10) @(posedge clk);
    #1 rsp_ready = 1'b0;
  endtask

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    test_reset();
    test_directed();
    test_random();
    test_stall();
    test_reset_mid();
    test_back_to_back();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
